spi_master: RTL
===============

# spi_master

SPI bus master (initiator) for the peripheral subsystem: accepts one transfer request over a valid/ready interface, drives sck/ss_n/mosi, captures miso and returns the received word. It is the controller end of the same mode-0, MSB-first SPI link our slave peripherals speak, and sits between the bus-facing register front end and the SPI pins.

## Interface
- DATA_W, 64: maximum transfer length in bits; also width of request/response data.
- SS_W, 8: number of slave-select lines.
- DIV_W, 8: width of the sck divider field.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request present.
- req_ready  out  1  high only in IDLE; transfer accepted when req_valid && req_ready.
- req_data  in  DATA_W  transmit data, right-justified; bit len-1 sent first.
- req_len  in  $clog2(DATA_W)  bit count; 0 means DATA_W.
- req_ss  in  SS_W  one-hot slave select (1 = selected).
- req_div  in  DIV_W  half-period H = req_div+1 clock cycles.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid. No back-pressure.
- rsp_data  out  DATA_W  received bits, right-justified, upper bits zero; held until next rsp_valid.
- busy  out  1  high in every state except IDLE.
- sck  out  1  SPI clock, idle low (CPOL=0).
- ss_n  out  SS_W  active-low selects, idle all-ones.
- mosi  out  1  serial data out, idle high.
- miso  in  1  serial data in.

## Operation
- Request fields (data, len, ss, div) latched on acceptance; later input changes ignored.
- States: IDLE -> SETUP -> SHIFT_HI / SHIFT_LO -> HOLD -> DONE -> IDLE.
- IDLE: req_ready=1, sck=0, ss_n=all ones, mosi=1. Accept -> SETUP.
- SETUP (H cycles): ss_n=~req_ss, mosi=first bit (data[len-1]), sck=0. -> SHIFT_HI.
- SHIFT_HI (H cycles): sck=1. -> SHIFT_LO.
- SHIFT_LO (H cycles): sck=0. Entry into SHIFT_LO samples miso (value present on the cycle sck falls), shifts it into the receive register LSB, and advances mosi to the next bit. After len-th sample -> HOLD, else -> SHIFT_HI.
- Late sampling (falling edge) is mandatory: our slaves update miso off rising sck.
- HOLD (H cycles): sck=0, ss_n still asserted, mosi=1. -> DONE.
- DONE (1 cycle): ss_n=all ones, rsp_valid=1, rsp_data updated. -> IDLE.
- Bit counter width $clog2(DATA_W)+1; len=0 loads DATA_W.
- req_ss=0 or multi-hot: transfer runs unchanged, ss_n driven as given.
- Reset at any point: next cycle IDLE, ss_n all ones, no rsp_valid.

## Timing
- Reset values: req_ready=0 during reset, 1 after; rsp_valid=0, rsp_data=0, busy=0, sck=0, ss_n=all ones, mosi=1.
- Accept at cycle T: ss_n asserted from T+1; rsp_valid at T+1+(2*len+2)*H exactly.
- sck: len rising edges, each high phase and low phase exactly H cycles.
- ss_n asserted for (2*len+2)*H cycles, deasserted in DONE.
- Next request accepted earliest at cycle after DONE (one IDLE cycle minimum).
- All outputs registered.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: extra input port loopback (1 bit). When 1 at acceptance, the transfer samples internal mosi instead of miso and holds ss_n all ones for the whole transfer; timing unchanged.
- Undefined: port absent, miso always used.

## Structure
- spi_master_pkg: state enum, DATA_W/SS_W/DIV_W defaults, length-width constant.
- One sub-module spi_clkgen: H-cycle half-period counter producing a phase-end tick; reloaded on every state change.
- Shift/bit-count registers and FSM in spi_master.

## Test plan
- Reset: hold reset 3 cycles -> sck=0, ss_n=8'hFF, mosi=1, rsp_valid=0, busy=0; req_ready=1 first cycle after.
- Loopback, div=0, len=8, data=0xA5, ss=0x01 -> rsp_data=0xA5, rsp_valid at T+19, 8 sck rising edges, ss_n stays 8'hFF.
- Behavioural mode-0 slave on ss 0x04, div=0, len=8, data=0x3C, slave returns 0xC3 -> mosi bit sequence 0,0,1,1,1,1,0,0; rsp_data=0xC3; ss_n=8'hFB during T+1..T+18.
- div=3, len=1, data=1, miso tied 0 -> sck high exactly 4 cycles, rsp_data=0, rsp_valid at T+17.
- len=0, div=0, miso tied 1 -> 64 sck edges, rsp_data=64'hFFFF_FFFF_FFFF_FFFF, rsp_valid at T+131.
- req_valid held high across a transfer -> second accepted only after DONE; reset asserted mid-SHIFT -> ss_n=all ones next cycle, no rsp_valid.

Source files
------------

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and default sizes for the SPI master.
// Contents: FSM state enum, default DATA_W/SS_W/DIV_W, length-field width helper.
package spi_master_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int SS_W_DEF   = 8;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_DONE
  } state_e;

  function automatic int len_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period timer; tick_o marks the last cycle of a div_i+1 cycle phase.
// Ports: clk_i, rst_i (sync, active high), restart_i (reload on state change),
//        div_i (half period minus one), tick_o (phase-end tick).
module spi_clkgen
  import spi_master_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = restart_i ? '0 : cnt_q + DIV_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = cnt_q == div_i;

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0, MSB-first SPI initiator with valid/ready request and pulsed response.
// Ports: clk_i, rst_i (sync, active high); req_valid_i/req_ready_o handshake with
//        req_data_i, req_len_i (0 = DATA_W), req_ss_i (one-hot), req_div_i (H = div+1);
//        rsp_valid_o pulse with rsp_data_o; busy_o; SPI pins sck_o, ss_n_o, mosi_o, miso_i.
// Build option SPI_MASTER_LOOPBACK_EN adds loopback_i: mosi is sampled instead of miso
// and ss_n stays deasserted for that transfer.
module spi_master
  import spi_master_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int SS_W   = SS_W_DEF,
  parameter  int DIV_W  = DIV_W_DEF,
  localparam int LEN_W  = $clog2(DATA_W),
  localparam int CNT_W  = LEN_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [SS_W-1:0]   req_ss_i,
  input  logic [DIV_W-1:0]  req_div_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              sck_o,
  output logic [SS_W-1:0]   ss_n_o,
  output logic              mosi_o,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  input  logic              miso_i
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_eff;
  logic [SS_W-1:0]   ss_q, ss_d, ss_n_q, ss_n_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              lb_q, lb_d, lb_in, rx_bit, tick, accept, active;
  logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d, sck_q, sck_d, mosi_q, mosi_d;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_in = loopback_i;
`else
  assign lb_in = 1'b0;
`endif

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (state_d != state_q),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    ss_d    = ss_q;
    div_d   = div_q;
    lb_d    = lb_q;
    accept  = req_valid_i && req_ready_q;
    len_eff = (req_len_i == '0) ? CNT_W'(DATA_W) : CNT_W'(req_len_i);
    rx_bit  = lb_q ? mosi_q : miso_i;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_SETUP;
        // left-justify so the first bit to send sits in the MSB
        tx_d    = req_data_i << (CNT_W'(DATA_W) - len_eff);
        rx_d    = '0;
        cnt_d   = len_eff;
        ss_d    = req_ss_i;
        div_d   = req_div_i;
        lb_d    = lb_in;
      end
      ST_SETUP: state_d = tick ? ST_SHIFT_HI : ST_SETUP;
      // falling sck edge: sample and advance, slaves change miso off the rising edge
      ST_SHIFT_HI: if (tick) begin
        state_d = ST_SHIFT_LO;
        rx_d    = {rx_q[DATA_W-2:0], rx_bit};
        tx_d    = {tx_q[DATA_W-2:0], 1'b1};
        cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SHIFT_LO: if (tick) state_d = (cnt_q == '0) ? ST_HOLD : ST_SHIFT_HI;
      ST_HOLD: state_d = tick ? ST_DONE : ST_HOLD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    active      = state_d inside {ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO, ST_HOLD};
    req_ready_d = state_d == ST_IDLE;
    busy_d      = state_d != ST_IDLE;
    sck_d       = state_d == ST_SHIFT_HI;
    rsp_valid_d = state_d == ST_DONE;
    rsp_data_d  = (state_d == ST_DONE) ? rx_q : rsp_data_q;
    ss_n_d      = (active && !lb_d) ? ~ss_d : '1;
    mosi_d      = (state_d inside {ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO}) ? tx_d[DATA_W-1] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      ss_q        <= '0;
      div_q       <= '0;
      lb_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      sck_q       <= 1'b0;
      ss_n_q      <= '1;
      mosi_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      ss_q        <= ss_d;
      div_q       <= div_d;
      lb_q        <= lb_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      sck_q       <= sck_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = busy_q;
  assign sck_o       = sck_q;
  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;

endmodule
